// File: rtl/kuart_pkg.sv
// -----------------------------------------------------------------------------
// kuart_pkg
//   Shared definitions for the simulation-side kernel UART path: the receive
//   FSM state encoding, the default bit period and the ASCII bytes that the
//   finisher and the TX driver look for.
// -----------------------------------------------------------------------------
package kuart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // 100 MHz / 115200 baud
    localparam int DEFAULT_BAUD_DIV = 868;

    localparam logic [7:0] CH_DOT = 8'h2E;  // end-of-RAM-dump marker
    localparam logic [7:0] CH_R   = 8'h72;

endpackage : kuart_pkg

// File: rtl/kuart_rx_decoder_if.sv
// -----------------------------------------------------------------------------
// kuart_rx_decoder_if
//   Bundles the serial input and the decoded byte stream of kuart_rx_decoder.
//   master : the decoder (consumes uart_rx, produces the byte stream)
//   slave  : the environment (drives uart_rx, observes the byte stream)
//   Signals:
//     uart_rx    serial line, idle high, asynchronous to clk
//     rx_data    last received byte, holds until the next good frame
//     rx_valid   1-cycle strobe, rx_data valid
//     frame_err  1-cycle strobe, stop bit sampled low
//     rx_count   number of good frames received (wraps)
//     busy       receiver not idle
// -----------------------------------------------------------------------------
interface kuart_rx_decoder_if;

    logic        uart_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [31:0] rx_count;
    logic        busy;

    modport master (
        input  uart_rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_count,
        output busy
    );

    modport slave (
        output uart_rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_count,
        input  busy
    );

endinterface : kuart_rx_decoder_if

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     i_d         asynchronous input
//     o_q         synchronized output (2-cycle latency)
//   RST_VAL sets both flops on reset so an idle-high line does not look like
//   a falling edge when reset is released.
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make r_sync take the old r_meta, giving
    // a real two-stage pipeline; blocking here would collapse it to one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/kuart_rx_decoder.sv
// -----------------------------------------------------------------------------
// kuart_rx_decoder
//   8N1, LSB-first UART receiver feeding the simulation finisher with a clean
//   byte stream. Reports framing errors and counts good bytes.
//   Ports:
//     clk    single clock, all logic on posedge
//     rst_n  asynchronous active-low reset (aborts any frame in progress)
//     bus    kuart_rx_decoder_if.master (uart_rx in; rx_data, rx_valid,
//            frame_err, rx_count, busy out)
//   Parameters:
//     BAUD_DIV  clk cycles per bit, 4..65535
//     CNT_W     bit-timing counter width, must hold BAUD_DIV-1
// -----------------------------------------------------------------------------
module kuart_rx_decoder
    import kuart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int CNT_W    = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    kuart_rx_decoder_if.master   bus
);

    // Half-bit uses floor(BAUD_DIV/2) so odd dividers still land mid-bit.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

    rx_state_t        r_state;
    rx_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic [31:0]      r_rx_count;

    logic w_rx_s;
    logic w_cnt_zero;
    logic w_load_half;
    logic w_load_full;
    logic w_shift;
    logic w_good_stop;
    logic w_bad_stop;
    logic w_busy;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.uart_rx),
        .o_q   (w_rx_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for w_state_next.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!w_rx_s) w_state_next = START;
            START:   if (w_cnt_zero) w_state_next = w_rx_s ? IDLE : DATA;
            DATA:    if (w_cnt_zero && (r_bit_idx == 3'd7)) w_state_next = STOP;
            STOP:    if (w_cnt_zero) w_state_next = w_rx_s ? IDLE : BREAK;
            BREAK:   if (w_rx_s) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath strobes ----------------
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift     = 1'b0;
        w_good_stop = 1'b0;
        w_bad_stop  = 1'b0;
        case (r_state)
            IDLE:  w_load_half = !w_rx_s;
            START: w_load_full = w_cnt_zero && !w_rx_s;
            DATA: begin
                w_shift     = w_cnt_zero;
                w_load_full = w_cnt_zero;  // also times the stop bit after bit 7
            end
            STOP: begin
                w_good_stop = w_cnt_zero && w_rx_s;
                w_bad_stop  = w_cnt_zero && !w_rx_s;
            end
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_count  <= '0;
        end else begin
            if (w_load_half) begin
                r_cnt <= HALF_M1;
            end else if (w_load_full) begin
                r_cnt <= FULL_M1;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_load_half) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            // LSB arrives first, so shifting in at the MSB leaves bit 0 at [0].
            if (w_shift) begin
                r_shreg <= {w_rx_s, r_shreg[7:1]};
            end

            r_rx_valid  <= w_good_stop;
            r_frame_err <= w_bad_stop;
            if (w_good_stop) begin
                r_rx_data  <= r_shreg;
                r_rx_count <= r_rx_count + 1'b1;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.rx_count  = r_rx_count;
    assign bus.busy      = w_busy;

endmodule : kuart_rx_decoder
